// File: rtl/ram1_arb_pkg.sv
// ram1_arb_pkg: state encodings, requester ids and default UART register addresses for ram1_arbiter
package ram1_arb_pkg;
  typedef enum logic [2:0] {IDLE, SRAM_RD, SRAM_WR_SETUP, SRAM_WR_PULSE, SRAM_WR_HOLD, UART_BUSY, DONE} state_t;
  typedef enum logic [2:0] {U_IDLE, UART_RD_WAIT, UART_RD, UART_WR_PULSE, UART_WR_WAIT} uart_state_t;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_MEM = 1'b1;
  localparam logic [15:0] UART_DATA_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_DEF = 16'hBF01;
  localparam int CNT_W = 8;
endpackage

// File: rtl/ram1_arbiter_uart_seq.sv
// uart_seq: UART rdn/wrn strobe sequencing, launched by start and reporting a one-cycle done
module uart_seq
  import ram1_arb_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic we,
  input  logic tbre,
  input  logic tsre,
  input  logic data_ready,
  output logic rdn,
  output logic wrn,
  output logic drive,
  output logic done
);
  uart_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic tbre_seen;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= U_IDLE;
      cnt <= '0;
      tbre_seen <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n == state) ? cnt + CNT_W'(1) : '0;
      tbre_seen <= (state == UART_WR_WAIT) && (tbre_seen || tbre);
    end
  // a write completes once the holding buffer has emptied and then the shift register too
  always_comb begin
    state_n = state;
    done = 1'b0;
    case (state)
      U_IDLE: state_n = start ? (we ? UART_WR_PULSE : UART_RD_WAIT) : U_IDLE;
      UART_RD_WAIT: state_n = data_ready ? UART_RD : UART_RD_WAIT;
      UART_RD: done = cnt == CNT_W'(SRAM_WAIT);
      UART_WR_PULSE: state_n = UART_WR_WAIT;
      UART_WR_WAIT: done = (tbre_seen || tbre) && tsre;
      default: state_n = U_IDLE;
    endcase
    if (done) state_n = U_IDLE;
  end
  assign rdn = state != UART_RD;
  assign wrn = state != UART_WR_PULSE;
  assign drive = state == UART_WR_PULSE;
endmodule

// File: rtl/ram1_arbiter.sv
// ram1_arbiter: shares the RAM1 SRAM/UART bus between IF and MEM; define ARB_FAIR_EN to bound IF starvation
module ram1_arbiter
  import ram1_arb_pkg::*;
#(
  parameter int SRAM_WAIT = 1,
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_DEF
`ifdef ARB_FAIR_EN
  , parameter int FAIR_LIMIT = 2
`endif
) (
  input  logic        rai_clk,
  input  logic        rai_rst,
  input  logic        rai_if_req,
  input  logic [15:0] rai_if_addr,
  output logic        rao_if_ack,
  output logic [15:0] rao_if_data,
  input  logic        rai_mem_req,
  input  logic        rai_mem_we,
  input  logic [15:0] rai_mem_addr,
  input  logic [15:0] rai_mem_wdata,
  output logic        rao_mem_ack,
  output logic [15:0] rao_mem_rdata,
  output logic        rao_ram1_en,
  output logic        rao_ram1_we,
  output logic        rao_ram1_oe,
  output logic [15:0] rao_ram1_addr,
  inout  wire  [15:0] raio_ram1_data,
  input  logic        rai_uart_tbre,
  input  logic        rai_uart_tsre,
  input  logic        rai_uart_data_ready,
  output logic        rao_uart_wrn,
  output logic        rao_uart_rdn,
  output logic        rao_busy
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic owner, we_r, force_if, grant_mem, grant_if, is_data, is_stat, u_done, u_drive, drive;
  logic [15:0] addr_r, wdata_r;
  assign is_data = rai_mem_addr == UART_DATA_ADDR;
  assign is_stat = rai_mem_addr == UART_STAT_ADDR;
`ifdef ARB_FAIR_EN
  logic [1:0] fair_cnt;
  assign force_if = rai_if_req && (fair_cnt >= 2'(FAIR_LIMIT));
  always_ff @(posedge rai_clk or negedge rai_rst)
    if (!rai_rst) fair_cnt <= '0;
    else if (!rai_if_req || grant_if) fair_cnt <= '0;
    else if (grant_mem) fair_cnt <= fair_cnt + 2'd1;
`else
  assign force_if = 1'b0;
`endif
  assign grant_mem = (state == IDLE) && rai_mem_req && !force_if;
  assign grant_if = (state == IDLE) && rai_if_req && !grant_mem;
  uart_seq #(.SRAM_WAIT(SRAM_WAIT)) u_uart (
    .clk(rai_clk),
    .rst_n(rai_rst),
    .start(grant_mem && is_data),
    .we(rai_mem_we),
    .tbre(rai_uart_tbre),
    .tsre(rai_uart_tsre),
    .data_ready(rai_uart_data_ready),
    .rdn(rao_uart_rdn),
    .wrn(rao_uart_wrn),
    .drive(u_drive),
    .done(u_done)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = grant_mem ? (is_data ? UART_BUSY : is_stat ? DONE : rai_mem_we ? SRAM_WR_SETUP : SRAM_RD)
                                : grant_if ? SRAM_RD : IDLE;
      SRAM_RD: state_n = (cnt == CNT_W'(SRAM_WAIT)) ? DONE : SRAM_RD;
      SRAM_WR_SETUP: state_n = SRAM_WR_PULSE;
      SRAM_WR_PULSE: state_n = (cnt == CNT_W'(SRAM_WAIT - 1)) ? SRAM_WR_HOLD : SRAM_WR_PULSE;
      SRAM_WR_HOLD: state_n = DONE;
      UART_BUSY: state_n = u_done ? DONE : UART_BUSY;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge rai_clk or negedge rai_rst)
    if (!rai_rst) begin
      state <= IDLE;
      cnt <= '0;
      owner <= REQ_IF;
      we_r <= 1'b0;
      addr_r <= '0;
      wdata_r <= '0;
      rao_if_data <= '0;
      rao_mem_rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n == state) ? cnt + CNT_W'(1) : '0;
      if (grant_mem || grant_if) begin
        owner <= grant_mem ? REQ_MEM : REQ_IF;
        we_r <= grant_mem && rai_mem_we;
        addr_r <= grant_mem ? rai_mem_addr : rai_if_addr;
        wdata_r <= rai_mem_wdata;
      end
      if (grant_mem && is_stat && !rai_mem_we)
        rao_mem_rdata <= {14'b0, rai_uart_data_ready, rai_uart_tbre && rai_uart_tsre};
      if (state == SRAM_RD && state_n == DONE) begin
        if (owner == REQ_MEM) rao_mem_rdata <= raio_ram1_data;
        else rao_if_data <= raio_ram1_data;
      end
      if (state == UART_BUSY && u_done && !we_r) rao_mem_rdata <= {8'h00, raio_ram1_data[7:0]};
    end
  assign drive = (state inside {SRAM_WR_SETUP, SRAM_WR_PULSE, SRAM_WR_HOLD}) || u_drive;
  assign raio_ram1_data = drive ? (u_drive ? {8'h00, wdata_r[7:0]} : wdata_r) : 16'hzzzz;
  assign rao_ram1_en = !(state inside {SRAM_RD, SRAM_WR_SETUP, SRAM_WR_PULSE, SRAM_WR_HOLD});
  assign rao_ram1_oe = state != SRAM_RD;
  assign rao_ram1_we = state != SRAM_WR_PULSE;
  assign rao_ram1_addr = addr_r;
  assign rao_if_ack = (state == DONE) && (owner == REQ_IF);
  assign rao_mem_ack = (state == DONE) && (owner == REQ_MEM);
  assign rao_busy = state != IDLE;
endmodule

// File: tb/tb_ram1_arbiter.sv
// tb_ram1_arbiter: randomized checks of ram1_arbiter against SRAM/UART behaviour models
module tb_ram1_arbiter;
  localparam int SW = 1;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, mem_req = 0, mem_we = 0;
  logic [15:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic tbre = 1, tsre = 1, data_ready = 0;
  wire if_ack, mem_ack, en, we, oe, wrn, rdn, busy;
  wire [15:0] if_data, mem_rdata, ram1_addr, bus;
  logic [15:0] sram [0:65535];
  logic [15:0] ref_mem [0:31];
  logic [15:0] uart_rx = 0, pre_a = 0, pre_d = 0;
  logic pre_we = 0;
  int oe_lo = 0, we_lo = 0, rdn_lo = 0, wrn_lo = 0;
  logic [15:0] we_bus = 0, wrn_bus = 0;
  int n_checks = 0, n_pass = 0;
  always #5 clk = ~clk;
  ram1_arbiter #(.SRAM_WAIT(SW)) dut (
    .rai_clk(clk), .rai_rst(rst_n),
    .rai_if_req(if_req), .rai_if_addr(if_addr), .rao_if_ack(if_ack), .rao_if_data(if_data),
    .rai_mem_req(mem_req), .rai_mem_we(mem_we), .rai_mem_addr(mem_addr), .rai_mem_wdata(mem_wdata),
    .rao_mem_ack(mem_ack), .rao_mem_rdata(mem_rdata),
    .rao_ram1_en(en), .rao_ram1_we(we), .rao_ram1_oe(oe), .rao_ram1_addr(ram1_addr),
    .raio_ram1_data(bus),
    .rai_uart_tbre(tbre), .rai_uart_tsre(tsre), .rai_uart_data_ready(data_ready),
    .rao_uart_wrn(wrn), .rao_uart_rdn(rdn), .rao_busy(busy)
  );
  // SRAM and UART answer reads; a keeper pattern marks cycles where nobody may drive the bus
  assign bus = (!en && !oe) ? sram[ram1_addr] : !rdn ? uart_rx : (en && wrn && rdn) ? 16'hA5A5 : 16'hzzzz;
  always @(negedge clk) begin
    if (!oe) oe_lo <= oe_lo + 1;
    if (!we) begin we_lo <= we_lo + 1; we_bus <= bus; end
    if (!rdn) rdn_lo <= rdn_lo + 1;
    if (!wrn) begin wrn_lo <= wrn_lo + 1; wrn_bus <= bus; end
    if (!en && !we) sram[ram1_addr] <= bus;
    else if (pre_we) sram[pre_a] <= pre_d;
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_we = 1;
    @(negedge clk); #1;
    pre_we = 0;
    if (a < 32) ref_mem[a[4:0]] = d;
    tick();
  endtask
  task automatic mem_op(input logic w, input logic [15:0] a, input logic [15:0] d, output int lat, output logic [15:0] rd);
    mem_we = w; mem_addr = a; mem_wdata = d; mem_req = 1; lat = 0;
    do begin tick(); lat++; end while (!mem_ack && lat < 200);
    rd = mem_rdata; mem_req = 0;
    tick();
  endtask
  task automatic if_op(input logic [15:0] a, output int lat, output logic [15:0] rd);
    if_addr = a; if_req = 1; lat = 0;
    do begin tick(); lat++; end while (!if_ack && lat < 200);
    rd = if_data; if_req = 0;
    tick();
  endtask
  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if ({en, we, oe, wrn, rdn, if_ack, mem_ack, busy} !== 8'b11111000) $display("FAIL reset_ctrl got %b want 11111000", {en, we, oe, wrn, rdn, if_ack, mem_ack, busy}); else n_pass++;
    n_checks++; if ({ram1_addr, if_data, mem_rdata} !== 48'h0) $display("FAIL reset_regs got %h want 0", {ram1_addr, if_data, mem_rdata}); else n_pass++;
    n_checks++; if (bus !== 16'hA5A5) $display("FAIL reset_bus got %h want a5a5 (undriven)", bus); else n_pass++;
    rst_n = 1;
    tick();
  endtask
  task automatic test_if_read();
    int lat, o0; logic [15:0] rd;
    preload(16'h0010, 16'h1234);
    o0 = oe_lo;
    if_op(16'h0010, lat, rd);
    n_checks++; if (lat !== SW + 2) $display("FAIL if_lat got %0d want %0d", lat, SW + 2); else n_pass++;
    n_checks++; if (rd !== 16'h1234) $display("FAIL if_data got %h want 1234", rd); else n_pass++;
    n_checks++; if (oe_lo - o0 !== SW + 1) $display("FAIL if_oe_cycles got %0d want %0d", oe_lo - o0, SW + 1); else n_pass++;
  endtask
  task automatic test_mem_write();
    int lat, w0; logic [15:0] rd;
    w0 = we_lo;
    mem_op(1'b1, 16'h8000, 16'hBEEF, lat, rd);
    n_checks++; if (lat !== SW + 3) $display("FAIL wr_lat got %0d want %0d", lat, SW + 3); else n_pass++;
    n_checks++; if (we_lo - w0 !== SW) $display("FAIL wr_we_cycles got %0d want %0d", we_lo - w0, SW); else n_pass++;
    n_checks++; if (we_bus !== 16'hBEEF) $display("FAIL wr_bus got %h want beef", we_bus); else n_pass++;
    n_checks++; if (bus !== 16'hA5A5) $display("FAIL wr_bus_after got %h want a5a5 (undriven)", bus); else n_pass++;
    mem_op(1'b0, 16'h8000, 16'h0, lat, rd);
    n_checks++; if (rd !== 16'hBEEF || lat !== SW + 2) $display("FAIL wr_readback got %h/%0d want beef/%0d", rd, lat, SW + 2); else n_pass++;
  endtask
  task automatic test_simultaneous();
    int t, mt, it; logic [15:0] md, id, x, y;
    x = 16'($urandom); y = 16'($urandom);
    preload(16'h0020, x);
    preload(16'h0021, y);
    if_addr = 16'h0020; mem_addr = 16'h0021; mem_we = 0; if_req = 1; mem_req = 1;
    t = 0; mt = 0; it = 0; md = 0; id = 0;
    while ((mt == 0 || it == 0) && t < 100) begin
      tick(); t++;
      if (mem_ack && mt == 0) begin mt = t; md = mem_rdata; mem_req = 0; end
      if (if_ack && it == 0) begin it = t; id = if_data; if_req = 0; end
    end
    mem_req = 0; if_req = 0;
    tick();
    n_checks++; if (mt !== SW + 2) $display("FAIL sim_mem_lat got %0d want %0d", mt, SW + 2); else n_pass++;
    n_checks++; if (it !== mt + SW + 3) $display("FAIL sim_if_lat got %0d want %0d", it, mt + SW + 3); else n_pass++;
    n_checks++; if ({md, id} !== {y, x}) $display("FAIL sim_data got %h want %h", {md, id}, {y, x}); else n_pass++;
  endtask
  task automatic test_uart_read();
    int lat, r0; logic [15:0] rd;
    uart_rx = 16'hAB41; data_ready = 0; r0 = rdn_lo;
    fork
      mem_op(1'b0, 16'hBF00, 16'h0, lat, rd);
      begin repeat (5) tick(); data_ready = 1; end
    join
    data_ready = 0;
    n_checks++; if (rdn_lo - r0 !== SW + 1) $display("FAIL urd_rdn_cycles got %0d want %0d", rdn_lo - r0, SW + 1); else n_pass++;
    n_checks++; if (rd !== 16'h0041) $display("FAIL urd_data got %h want 0041", rd); else n_pass++;
    n_checks++; if (lat <= 5 || lat >= 200) $display("FAIL urd_lat got %0d want 6..199", lat); else n_pass++;
  endtask
  task automatic test_uart_write();
    int lat, w0, s0; logic [15:0] rd;
    tbre = 1; tsre = 0; w0 = wrn_lo; s0 = we_lo;
    fork
      mem_op(1'b1, 16'hBF00, 16'hA558, lat, rd);
      begin repeat (10) tick(); tsre = 1; end
    join
    n_checks++; if (wrn_lo - w0 !== 1) $display("FAIL uwr_wrn_cycles got %0d want 1", wrn_lo - w0); else n_pass++;
    n_checks++; if (wrn_bus !== 16'h0058) $display("FAIL uwr_bus got %h want 0058", wrn_bus); else n_pass++;
    n_checks++; if (lat <= 10 || lat >= 200) $display("FAIL uwr_tsre_lat got %0d want 11..199", lat); else n_pass++;
    n_checks++; if (we_lo !== s0) $display("FAIL uwr_sram_we got %0d want %0d", we_lo, s0); else n_pass++;
    tbre = 0; tsre = 1;
    fork
      mem_op(1'b1, 16'hBF00, 16'h0013, lat, rd);
      begin repeat (6) tick(); tbre = 1; end
    join
    n_checks++; if (lat <= 6 || lat >= 200) $display("FAIL uwr_tbre_lat got %0d want 7..199", lat); else n_pass++;
  endtask
  task automatic test_status();
    int lat, w0, u0; logic [15:0] rd, prev; logic dr, tb, ts;
    for (int i = 0; i < 4; i++) begin
      dr = 1'($urandom); tb = 1'($urandom); ts = 1'($urandom);
      data_ready = dr; tbre = tb; tsre = ts;
      mem_op(1'b0, 16'hBF01, 16'h0, lat, rd);
      n_checks++; if (lat !== 1) $display("FAIL stat_lat got %0d want 1", lat); else n_pass++;
      n_checks++; if (rd !== {14'b0, dr, tb & ts}) $display("FAIL stat_data got %h want %h", rd, {14'b0, dr, tb & ts}); else n_pass++;
    end
    prev = mem_rdata; w0 = we_lo; u0 = wrn_lo;
    mem_op(1'b1, 16'hBF01, 16'hFFFF, lat, rd);
    n_checks++; if ({lat == 1, rd, we_lo - w0, wrn_lo - u0} !== {1'b1, prev, 32'd0, 32'd0}) $display("FAIL stat_write got lat %0d rd %h we %0d wrn %0d want 1 %h 0 0", lat, rd, we_lo - w0, wrn_lo - u0, prev); else n_pass++;
    data_ready = 0; tbre = 1; tsre = 1;
  endtask
  task automatic test_random();
    int lat, w0; logic [15:0] rd, d; logic [4:0] a;
    for (int i = 0; i < 32; i++) preload(16'(i), 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom); d = 16'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          if_op({11'b0, a}, lat, rd);
          n_checks++; if ({lat == SW + 2, rd} !== {1'b1, ref_mem[a]}) $display("FAIL rnd_if[%0d] got %h lat %0d want %h lat %0d", i, rd, lat, ref_mem[a], SW + 2); else n_pass++;
        end
        1: begin
          mem_op(1'b0, {11'b0, a}, d, lat, rd);
          n_checks++; if ({lat == SW + 2, rd} !== {1'b1, ref_mem[a]}) $display("FAIL rnd_rd[%0d] got %h lat %0d want %h lat %0d", i, rd, lat, ref_mem[a], SW + 2); else n_pass++;
        end
        default: begin
          w0 = we_lo;
          mem_op(1'b1, {11'b0, a}, d, lat, rd);
          ref_mem[a] = d;
          n_checks++; if ({lat == SW + 3, we_bus, we_lo - w0} !== {1'b1, d, SW}) $display("FAIL rnd_wr[%0d] got %h lat %0d want %h lat %0d", i, we_bus, lat, d, SW + 3); else n_pass++;
        end
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask
  task automatic test_reset_mid();
    int lat; logic seen; logic [15:0] rd;
    mem_we = 1; mem_addr = 16'h8004; mem_wdata = 16'h5A5A; mem_req = 1;
    tick(); tick();
    n_checks++; if (we !== 1'b0) $display("FAIL rst_mid_pulse got we=%b want 0", we); else n_pass++;
    rst_n = 0; #1;
    n_checks++; if ({en, we, oe, wrn, rdn, mem_ack, busy} !== 7'b1111100) $display("FAIL rst_mid_ctrl got %b want 1111100", {en, we, oe, wrn, rdn, mem_ack, busy}); else n_pass++;
    n_checks++; if (bus !== 16'hA5A5) $display("FAIL rst_mid_bus got %h want a5a5 (undriven)", bus); else n_pass++;
    mem_req = 0; seen = 0;
    repeat (2) begin tick(); seen |= mem_ack; end
    rst_n = 1;
    repeat (3) begin tick(); seen |= mem_ack; end
    n_checks++; if ({seen, busy} !== 2'b00) $display("FAIL rst_mid_after got ack %b busy %b want 0 0", seen, busy); else n_pass++;
    mem_op(1'b1, 16'h8004, 16'h7E57, lat, rd);
    mem_op(1'b0, 16'h8004, 16'h0, lat, rd);
    n_checks++; if (rd !== 16'h7E57) $display("FAIL rst_mid_recover got %h want 7e57", rd); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_if_read();
    test_mem_write();
    test_simultaneous();
    test_uart_read();
    test_uart_write();
    test_status();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
